// File: rtl/tsense_scan_ctrl.sv
// rtl/tsense_scan_ctrl.sv - shared-bus SPI temperature sensor scan sequencer
module tsense_scan_ctrl #(
  parameter int NSENS      = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic             i_sysclk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [7:0]       i_thresh,
  input  logic             i_req,
  input  logic [2:0]       i_req_id,
  input  logic [NSENS-1:0] i_alarm_clr,
  input  logic             i_sio,
  output logic [NSENS-1:0] o_cs,
  output logic             o_sck,
  output logic             o_ack,
  output logic             o_busy,
  output logic             o_data_valid,
  output logic [2:0]       o_data_id,
  output logic [7:0]       o_data,
  output logic [NSENS-1:0] o_alarm
);

  localparam int            TW      = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] TMAX    = TW'(SAMPLE_DIV - 1);
  localparam logic [2:0]    LAST_ID = 3'(NSENS - 1);
  localparam logic [3:0]    NS4     = 4'(NSENS);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_LATCH, S_GAP} state_t;

  state_t           r_state, w_next_state;
  logic [4:0]       r_cnt, w_next_cnt;
  logic [2:0]       r_id, w_next_id;
  logic             r_scan, w_next_scan;
  logic             r_pending, w_next_pending;
  logic [TW-1:0]    r_timer;
  logic             w_wrap;
  logic             w_ack_next;
  logic             w_active_next;
  logic [NSENS-1:0] w_next_cs;
  logic [NSENS-1:0] w_alarm_set;
  logic [7:0]       r_shift;
  logic [NSENS-1:0] r_cs;
  logic             r_sck;
  logic             r_ack;
  logic             r_valid;
  logic [2:0]       r_data_id;
  logic [7:0]       r_data;
  logic [NSENS-1:0] r_alarm;

  assign w_wrap = i_en && (r_timer == TMAX);

  // Period timer: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge i_sysclk) begin
    if (i_rst || !i_en || r_timer == TMAX) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Next-state, transaction counter, sensor index and scan bookkeeping
  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt + 5'd1;
    w_next_id      = r_id;
    w_next_scan    = r_scan;
    w_next_pending = r_pending;
    w_ack_next     = 1'b0;
    // A wrap during a running scan is lost; during a single read it is remembered
    if (w_wrap && !r_pending && !r_scan) begin
      w_next_pending = 1'b1;
    end
    case (r_state)
      S_IDLE: begin
        w_next_cnt = 5'd0;
        if (i_req) begin
          w_ack_next  = 1'b1;
          w_next_scan = 1'b0;
          // Out-of-range IDs are acknowledged but never touch the bus
          if ({1'b0, i_req_id} < NS4) begin
            w_next_state = S_SETUP;
            w_next_id    = i_req_id;
          end
        end else if (r_pending || w_wrap) begin
          w_next_state   = S_SETUP;
          w_next_id      = 3'd0;
          w_next_scan    = 1'b1;
          w_next_pending = 1'b0;
        end
      end
      S_SETUP: begin
        if (r_cnt == 5'd1) begin
          w_next_state = S_SHIFT;
          w_next_cnt   = 5'd0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 5'd15) begin
          w_next_state = S_LATCH;
          w_next_cnt   = 5'd0;
        end
      end
      S_LATCH: begin
        w_next_state = S_GAP;
        w_next_cnt   = 5'd0;
      end
      S_GAP: begin
        if (r_cnt == 5'd1) begin
          w_next_cnt = 5'd0;
          if (r_scan && r_id != LAST_ID) begin
            w_next_state = S_SETUP;
            w_next_id    = r_id + 3'd1;
          end else begin
            w_next_state = S_IDLE;
            w_next_scan  = 1'b0;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 5'd0;
      end
    endcase
  end

  // Chip selects for the coming cycle: only the addressed sensor, only in SETUP/SHIFT
  always_comb begin
    w_next_cs     = '1;
    w_active_next = (w_next_state == S_SETUP) || (w_next_state == S_SHIFT);
    for (int k = 0; k < NSENS; k++) begin
      w_next_cs[k] = !(w_active_next && (w_next_id == 3'(k)));
    end
  end

  // Over-temperature detect on the freshly latched reading
  always_comb begin
    w_alarm_set = '0;
    for (int k = 0; k < NSENS; k++) begin
      w_alarm_set[k] = (r_state == S_LATCH) && (r_data_id == 3'(k)) && (r_data >= i_thresh);
    end
  end

  // State, bus pins, serial capture and reading registers
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_id      <= 3'd0;
      r_scan    <= 1'b0;
      r_pending <= 1'b0;
      r_cs      <= '1;
      r_sck     <= 1'b0;
      r_ack     <= 1'b0;
      r_valid   <= 1'b0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_data_id <= 3'd0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_id      <= w_next_id;
      r_scan    <= w_next_scan;
      r_pending <= w_next_pending;
      r_cs      <= w_next_cs;
      // SCK high on odd SHIFT counts gives eight pulses per transaction
      r_sck     <= (w_next_state == S_SHIFT) && w_next_cnt[0];
      r_ack     <= w_ack_next;
      r_valid   <= (w_next_state == S_LATCH);
      // Capture on the edge that raises SCK
      if (r_state == S_SHIFT && !r_cnt[0]) begin
        r_shift <= {r_shift[6:0], i_sio};
      end
      if (w_next_state == S_LATCH) begin
        r_data    <= r_shift;
        r_data_id <= r_id;
      end
    end
  end

  // Sticky alarms: a set in the same cycle as a clear wins
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_alarm <= '0;
    end else begin
      r_alarm <= w_alarm_set | (r_alarm & ~i_alarm_clr);
    end
  end

  assign o_cs         = r_cs;
  assign o_sck        = r_sck;
  assign o_ack        = r_ack;
  assign o_busy       = (r_state != S_IDLE);
  assign o_data_valid = r_valid;
  assign o_data_id    = r_data_id;
  assign o_data       = r_data;
  assign o_alarm      = r_alarm;

endmodule

// File: doc/tsense_scan_ctrl.md
# tsense_scan_ctrl

Sequencer that shares one SPI temperature-sensor bus (common SCK/SIO, one active-low CS per sensor) among up to NSENS sensors. It runs periodic round-robin scans and also accepts on-demand single reads. It delivers each 8-bit reading with its sensor ID and keeps sticky per-sensor over-temperature alarms. It sits between the sensor pins and the display/BCD path, replacing free-running single-sensor read logic.

## Interface
- NSENS, 4: number of sensors on the shared bus, 2..8.
- SAMPLE_DIV, 1000: scan period in SYSCLK cycles, minimum 200.
- SYSCLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  enables periodic scanning.
- THRESH  in  8  alarm threshold, unsigned.
- REQ  in  1  on-demand read request; hold until ACK.
- REQ_ID  in  3  sensor index for REQ; values >= NSENS are legal.
- ALARM_CLR  in  NSENS  per-sensor alarm clear strobes.
- SIO  in  1  shared serial data from the sensors.
- CS  out  NSENS  per-sensor chip selects, active-low.
- SCK  out  1  SPI clock, registered.
- ACK  out  1  one-cycle pulse when REQ is accepted.
- BUSY  out  1  high whenever the state is not IDLE.
- DATA_VALID  out  1  one-cycle pulse when a reading completes.
- DATA_ID  out  3  sensor index of DATA.
- DATA  out  8  last reading, MSB first off the wire.
- ALARM  out  NSENS  sticky over-temperature flags.

## Operation
- States:
  - IDLE
  - SETUP: 2 cycles.
  - SHIFT: 16 cycles.
  - LATCH: 1 cycle.
  - GAP: 2 cycles.
- Period timer:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - While EN=0 it is held at 0.
  - A wrap with EN=1 sets scan_pending.
  - A wrap while scan_pending is already set, or while a scan is running, is dropped. No queue is kept.
- Leaving IDLE, in priority order:
  - REQ=1: ACK pulses, single read of REQ_ID. scan_pending is left untouched.
  - Otherwise, scan_pending=1: scan_pending is cleared, scan of sensors 0..NSENS-1 in order.
  - REQ is sampled only in IDLE. A REQ raised mid-scan waits for the scan to end.
- REQ_ID >= NSENS:
  - ACK pulses.
  - No CS asserts, no DATA_VALID.
  - Returns to IDLE next cycle.
- Per-sensor transaction (cycle 0 = first SETUP cycle):
  - CS[k]=0 during cycles 0..17. All other CS stay 1.
  - SCK=0 in SETUP. In SHIFT it toggles every cycle starting from 0, so it is high in cycles 3,5,...,17 (eight pulses). SCK=0 from cycle 18.
  - SIO is shifted in, MSB first, on each SYSCLK edge that drives SCK 0->1.
  - Cycle 18 (LATCH): CS[k]=1, DATA/DATA_ID updated, DATA_VALID=1.
  - GAP: all CS high. Then next sensor's SETUP, or IDLE after the last sensor / single read.
- Alarm:
  - At LATCH, ALARM[k] is set if DATA >= THRESH (unsigned).
  - ALARM_CLR[k] clears it.
  - Set and clear in the same cycle: set wins.
- EN dropped mid-scan: the scan completes. No new scan is started.
- BUSY=1 from the first SETUP cycle through the last GAP cycle.

## Timing
- Reset values (RST, takes effect on the next edge, aborts any transaction):
  - State IDLE, timer 0, scan_pending 0.
  - CS all 1, SCK 0.
  - ACK, BUSY, DATA_VALID 0.
  - DATA 0, DATA_ID 0, ALARM 0.
- Timer wrap at edge T with EN=1 and IDLE, no REQ: SETUP starts at T+1, so CS[0] falls in cycle T+1.
- REQ in IDLE at edge T: ACK high in cycle T+1, CS[REQ_ID] low in cycle T+1. The requester drops REQ after seeing ACK.
- Per-sensor cost is 21 cycles. A full scan lasts 21*NSENS cycles. DATA_VALID for sensor k falls at 21k+18 after scan start.
- DATA and DATA_ID hold their value until the next LATCH.

## Test plan
- Periodic scan: SAMPLE_DIV=200, NSENS=4, EN=1, sensor k returns 8'h10+k.
  - Required: DATA_VALID at scan-relative cycles 18, 39, 60, 81, with DATA 10,11,12,13 (hex) and DATA_ID 0..3.
  - Required: next scan starts 200 cycles after the previous one.
- On-demand read: REQ=1, REQ_ID=2 in IDLE, sensor returns 8'hA5.
  - Required: ACK one cycle, only CS[2] low for 18 cycles, 8 SCK pulses, DATA=8'hA5, DATA_ID=2.
- Priority collision: timer wrap and REQ (REQ_ID=1) in the same cycle.
  - Required: the single read of sensor 1 executes first, then the full scan starts immediately after its GAP.
  - Required: a REQ raised mid-scan gets ACK only after the final GAP.
- Alarm: THRESH=8'h30, sensor 3 returns 8'h30 and then 8'h2F.
  - Required: ALARM[3] is set after the first read and stays set after the second.
  - Required: ALARM_CLR[3] coinciding with a LATCH >= THRESH leaves ALARM[3]=1. A lone clear gives 0.
- Reset mid-SHIFT: RST at SHIFT cycle 9.
  - Required: next cycle all CS=1, SCK=0, BUSY=0, DATA=0, no DATA_VALID.
  - Required: after release, the timer restarts from 0.
- Invalid ID and EN drop:
  - REQ_ID=6 with NSENS=4: ACK pulses, no CS activity, no DATA_VALID.
  - EN=0 during sensor 1 of a scan: sensors 1..3 still complete, and no further scan starts.
